// File: rtl/sum_display_pkg.sv
// Shared constants for the binary-to-decimal seven-segment display:
// datapath widths, FSM state encoding, segment patterns and the
// double-dabble step helper.
package sum_display_pkg;

  // Datapath widths
  localparam int VALUE_W   = 9;                  // binary operand bits
  localparam int BCD_W     = 12;                 // three BCD digits
  localparam int SR_W      = VALUE_W + BCD_W;    // combined shift register
  localparam int NUM_STEPS = 9;                  // one step per operand bit
  localparam int CNT_W     = 4;                  // step counter width
  localparam int DIGIT_W   = 4;
  localparam int SEG_W     = 7;

  // Counter value during the final double-dabble step
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(NUM_STEPS - 1);

  // FSM state encoding
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SHIFT  = 2'd1;
  localparam logic [1:0] ST_UPDATE = 2'd2;

  // Active-low segment patterns, bit6=g .. bit0=a
  localparam logic [SEG_W-1:0] SEG_0     = 7'b1000000;
  localparam logic [SEG_W-1:0] SEG_1     = 7'b1111001;
  localparam logic [SEG_W-1:0] SEG_2     = 7'b0100100;
  localparam logic [SEG_W-1:0] SEG_3     = 7'b0110000;
  localparam logic [SEG_W-1:0] SEG_4     = 7'b0011001;
  localparam logic [SEG_W-1:0] SEG_5     = 7'b0010010;
  localparam logic [SEG_W-1:0] SEG_6     = 7'b0000010;
  localparam logic [SEG_W-1:0] SEG_7     = 7'b1111000;
  localparam logic [SEG_W-1:0] SEG_8     = 7'b0000000;
  localparam logic [SEG_W-1:0] SEG_9     = 7'b0010000;
  localparam logic [SEG_W-1:0] SEG_BLANK = 7'b1111111;

  // One double-dabble step: every BCD nibble >= 5 gets +3, then the whole
  // register shifts left by one. The BCD field sits above the binary field.
  function automatic logic [SR_W-1:0] dabble_step(input logic [SR_W-1:0] sr);
    logic [SR_W-1:0] adj;
    adj = sr;
    for (int i = 0; i < BCD_W / DIGIT_W; i++) begin
      if (adj[VALUE_W + DIGIT_W*i +: DIGIT_W] >= 4'd5) begin
        adj[VALUE_W + DIGIT_W*i +: DIGIT_W] = adj[VALUE_W + DIGIT_W*i +: DIGIT_W] + 4'd3;
      end else begin
        adj[VALUE_W + DIGIT_W*i +: DIGIT_W] = adj[VALUE_W + DIGIT_W*i +: DIGIT_W];
      end
    end
    return {adj[SR_W-2:0], 1'b0};
  endfunction

endpackage

// File: rtl/bcd_to_seg.sv
// Combinational BCD digit to active-low seven-segment decoder with a
// blanking override for leading-zero suppression.
module bcd_to_seg
  import sum_display_pkg::*;
(
  input  logic [DIGIT_W-1:0] digit,
  input  logic               blank,
  output logic [SEG_W-1:0]   seg
);

  // Decode the digit, or force all segments off when blanked
  always_comb begin
    seg = SEG_BLANK;
    if (blank) begin
      seg = SEG_BLANK;
    end else begin
      case (digit)
        4'd0:    seg = SEG_0;
        4'd1:    seg = SEG_1;
        4'd2:    seg = SEG_2;
        4'd3:    seg = SEG_3;
        4'd4:    seg = SEG_4;
        4'd5:    seg = SEG_5;
        4'd6:    seg = SEG_6;
        4'd7:    seg = SEG_7;
        4'd8:    seg = SEG_8;
        4'd9:    seg = SEG_9;
        default: seg = SEG_BLANK;
      endcase
    end
  end

endmodule

// File: rtl/sum_hex_display.sv
// Converts a 9-bit binary value to three decimal digits with a sequential
// double-dabble engine and shows them on three seven-segment displays.
// A load starts a 9-step conversion; the new digits and a done pulse
// appear together ten cycles after the load.
module sum_hex_display
  import sum_display_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic [VALUE_W-1:0] value,
  output logic               busy,
  output logic               done,
  output logic [SEG_W-1:0]   HEX0,
  output logic [SEG_W-1:0]   HEX1,
  output logic [SEG_W-1:0]   HEX2
);

  logic [1:0]       state_q,  state_d;
  logic [SR_W-1:0]  sr_q,     sr_d;
  logic [CNT_W-1:0] cnt_q,    cnt_d;
  logic [BCD_W-1:0] digits_q, digits_d;
  logic             busy_q,   busy_d;
  logic             done_q,   done_d;
  logic [SEG_W-1:0] hex0_q,   hex0_d;
  logic [SEG_W-1:0] hex1_q,   hex1_d;
  logic [SEG_W-1:0] hex2_q,   hex2_d;
  logic             blank2_s;
  logic             blank1_s;

  // FSM, shift register and step counter next-state logic. The digit
  // register is loaded on the edge entering UPDATE so the new digits are
  // already on the display during the done cycle.
  always_comb begin
    state_d  = state_q;
    sr_d     = sr_q;
    cnt_d    = cnt_q;
    digits_d = digits_q;
    case (state_q)
      ST_IDLE: begin
        if (load) begin
          sr_d    = {{BCD_W{1'b0}}, value};
          cnt_d   = 4'd0;
          state_d = ST_SHIFT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        sr_d = dabble_step(sr_q);
        if (cnt_q == LAST_STEP) begin
          cnt_d    = 4'd0;
          digits_d = sr_d[SR_W-1:VALUE_W];
          state_d  = ST_UPDATE;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      ST_UPDATE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // Status flags registered from the next state so they align with it
  always_comb begin
    busy_d = (state_d == ST_SHIFT) || (state_d == ST_UPDATE);
    done_d = (state_d == ST_UPDATE);
  end

  // Leading-zero suppression on the next digit values
  always_comb begin
    blank2_s = (digits_d[11:8] == 4'd0);
    blank1_s = blank2_s && (digits_d[7:4] == 4'd0);
  end

  bcd_to_seg u_seg0 (
    .digit (digits_d[3:0]),
    .blank (1'b0),
    .seg   (hex0_d)
  );

  bcd_to_seg u_seg1 (
    .digit (digits_d[7:4]),
    .blank (blank1_s),
    .seg   (hex1_d)
  );

  bcd_to_seg u_seg2 (
    .digit (digits_d[11:8]),
    .blank (blank2_s),
    .seg   (hex2_d)
  );

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      sr_q     <= {SR_W{1'b0}};
      cnt_q    <= 4'd0;
      digits_q <= {BCD_W{1'b0}};
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      hex0_q   <= SEG_0;
      hex1_q   <= SEG_BLANK;
      hex2_q   <= SEG_BLANK;
    end else begin
      state_q  <= state_d;
      sr_q     <= sr_d;
      cnt_q    <= cnt_d;
      digits_q <= digits_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      hex0_q   <= hex0_d;
      hex1_q   <= hex1_d;
      hex2_q   <= hex2_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign HEX0 = hex0_q;
  assign HEX1 = hex1_q;
  assign HEX2 = hex2_q;

endmodule

// File: tb/tb_sum_hex_display.sv
// Directed self-checking bench for sum_hex_display with an expected-display
// scoreboard filled at load time and drained at each done pulse.
module tb_sum_hex_display;

  logic       clk   = 1'b0;
  logic       rst   = 1'b1;
  logic       load  = 1'b0;
  logic [8:0] value = 9'd0;
  logic       busy;
  logic       done;
  logic [6:0] HEX0;
  logic [6:0] HEX1;
  logic [6:0] HEX2;

  int tests = 0;
  int fails = 0;

  logic [20:0] exp_q[$];

  localparam logic [6:0] BLANK = 7'b1111111;
  logic [6:0] seg_tab [0:9] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                7'b0000000, 7'b0010000};

  sum_hex_display dut (
    .clk   (clk),
    .rst   (rst),
    .load  (load),
    .value (value),
    .busy  (busy),
    .done  (done),
    .HEX0  (HEX0),
    .HEX1  (HEX1),
    .HEX2  (HEX2)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Expected display {HEX2, HEX1, HEX0} for a decimal value
  function automatic logic [20:0] model(input int v);
    int d0, d1, d2;
    logic [6:0] h0, h1, h2;
    d0 = v % 10;
    d1 = (v / 10) % 10;
    d2 = v / 100;
    h0 = seg_tab[d0];
    h1 = (d2 == 0 && d1 == 0) ? BLANK : seg_tab[d1];
    h2 = (d2 == 0) ? BLANK : seg_tab[d2];
    return {h2, h1, h0};
  endfunction

  task automatic do_load(input logic [8:0] v, input bit push);
    if (push) exp_q.push_back(model(int'(v)));
    value = v;
    load  = 1'b1;
    tick();
    load  = 1'b0;
    value = 9'($urandom_range(0, 511));
    check("busy_after_load", {31'd0, busy}, 32'd1);
  endtask

  // n0 = clock edges elapsed since the accepting load edge (inclusive)
  task automatic wait_done(input string tag, input int n0);
    int n;
    int low_busy;
    int hex_moves;
    logic [20:0] prev;
    logic [20:0] e;
    n = n0;
    low_busy = 0;
    hex_moves = 0;
    prev = {HEX2, HEX1, HEX0};
    while (done !== 1'b1 && n < 20) begin
      if (busy !== 1'b1) low_busy++;
      if ({HEX2, HEX1, HEX0} !== prev) hex_moves++;
      tick();
      n++;
    end
    check({tag, "_latency"}, n, 32'd10);
    check({tag, "_busy_low"}, low_busy, 32'd0);
    check({tag, "_hex_early"}, hex_moves, 32'd0);
    check({tag, "_busy_done"}, {31'd0, busy}, 32'd1);
    check({tag, "_sb_size"}, exp_q.size(), 32'd1);
    if (exp_q.size() > 0) e = exp_q.pop_front();
    else e = 21'd0;
    check({tag, "_HEX0"}, {25'd0, HEX0}, {25'd0, e[6:0]});
    check({tag, "_HEX1"}, {25'd0, HEX1}, {25'd0, e[13:7]});
    check({tag, "_HEX2"}, {25'd0, HEX2}, {25'd0, e[20:14]});
  endtask

  task automatic after_done(input string tag);
    logic [20:0] held;
    held = {HEX2, HEX1, HEX0};
    tick();
    check({tag, "_done_off"}, {31'd0, done}, 32'd0);
    check({tag, "_busy_off"}, {31'd0, busy}, 32'd0);
    check({tag, "_hex_hold"}, {11'd0, HEX2, HEX1, HEX0}, {11'd0, held});
  endtask

  task automatic count_idle_done(input string tag, input int cycles);
    int pulses;
    pulses = 0;
    for (int i = 0; i < cycles; i++) begin
      tick();
      if (done === 1'b1) pulses++;
    end
    check({tag, "_no_done"}, pulses, 32'd0);
  endtask

  task automatic check_reset_display(input string tag);
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    check({tag, "_done"}, {31'd0, done}, 32'd0);
    check({tag, "_HEX0"}, {25'd0, HEX0}, {25'd0, 7'b1000000});
    check({tag, "_HEX1"}, {25'd0, HEX1}, {25'd0, BLANK});
    check({tag, "_HEX2"}, {25'd0, HEX2}, {25'd0, BLANK});
  endtask

  initial begin
    // Reset
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    check_reset_display("reset");

    // value 0 loaded at cycle 5 after reset release
    for (int i = 0; i < 4; i++) tick();
    do_load(9'd0, 1'b1);
    wait_done("v0", 1);
    after_done("v0");

    do_load(9'd511, 1'b1);
    wait_done("v511", 1);
    check("v511_HEX2_const", {25'd0, HEX2}, {25'd0, 7'b0010010});
    after_done("v511");

    do_load(9'd105, 1'b1);
    wait_done("v105", 1);
    check("v105_HEX1_const", {25'd0, HEX1}, {25'd0, 7'b1000000});
    after_done("v105");

    do_load(9'd9, 1'b1);
    wait_done("v9", 1);
    after_done("v9");

    // Load while busy is ignored
    do_load(9'd300, 1'b1);
    for (int i = 0; i < 3; i++) tick();
    value = 9'd42;
    load  = 1'b1;
    tick();
    load  = 1'b0;
    check("ign_busy_mid", {31'd0, busy}, 32'd1);
    wait_done("ign", 5);
    after_done("ign");
    count_idle_done("ign", 12);
    check("ign_hex_300", {11'd0, HEX2, HEX1, HEX0}, {11'd0, model(300)});

    // Reset aborts an in-flight conversion
    do_load(9'd255, 1'b0);
    for (int i = 0; i < 4; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_reset_display("abort");
    count_idle_done("abort", 12);
    do_load(9'd7, 1'b1);
    wait_done("v7", 1);
    after_done("v7");

    // Reset wins over a simultaneous load
    rst   = 1'b1;
    load  = 1'b1;
    value = 9'd99;
    tick();
    rst   = 1'b0;
    load  = 1'b0;
    check_reset_display("rst_prio");
    tick();
    check("rst_prio_idle", {31'd0, busy}, 32'd0);

    // Back-to-back: load in the cycle right after done
    do_load(9'd123, 1'b1);
    wait_done("v123", 1);
    after_done("v123");
    do_load(9'd10, 1'b1);
    wait_done("v10", 1);
    after_done("v10");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
